// File: rtl/instr_encoder.sv
// RV32I field packer: builds R/I/S/B/U/J words and queues them
// with sequential byte addresses in a small output FIFO.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   fmt,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [2:0]                   funct3,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  imm,
    input  logic                         addr_load,
    input  logic [ADDR_W-1:0]            addr_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic [31:0]       enc;
    logic              bad;
    logic              fire;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_ctr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];

    assign in_ready  = (count < CW'(DEPTH)) && !addr_load;
    assign fire      = in_valid && in_ready;
    assign push      = fire && !bad;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr] : '0;

    // Field packing and legality check for the offered field set
    always_comb begin
        enc = '0;
        bad = 1'b0;
        unique case (1'b1)
            (fmt == FMT_R): enc = {funct7, rs2, rs1, funct3, rd, opcode};
            (fmt == FMT_I): enc = {imm[11:0], rs1, funct3, rd, opcode};
            (fmt == FMT_S): enc = {imm[11:5], rs2, rs1, funct3,
                                   imm[4:0], opcode};
            (fmt == FMT_B): begin
                enc = {imm[12], imm[10:5], rs2, rs1, funct3,
                       imm[4:1], imm[11], opcode};
                bad = imm[0];
            end
            (fmt == FMT_U): enc = {imm[31:12], rd, opcode};
            (fmt == FMT_J): begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12],
                       rd, opcode};
                bad = imm[0];
            end
            default: bad = 1'b1;
        endcase
    end

    // Address counter: explicit load wins, else advance per queued word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_ctr <= BASE_ADDR;
        end else if (addr_load) begin
            addr_ctr <= addr_in;
        end else if (push) begin
            addr_ctr <= addr_ctr + ADDR_W'(4);
        end
    end

    // FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= enc;
            addr_mem[wr_ptr]  <= addr_ctr;
        end
    end

    // FIFO pointers, occupancy and one-cycle reject pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            err <= fire && bad;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
